// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use / jump-branch / ecall hazard controller
// Mealy control outputs from a four-state FSM plus saturating stall/flush counters.
module hazard_ctrl #(
  parameter int LOAD_LAT     = 1,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       d_rs1_index,
  input  logic [4:0]       d_rs2_index,
  input  logic             d_rs1_used,
  input  logic             d_rs2_used,
  input  logic [4:0]       e_rd_index,
  input  logic             e_wb_en,
  input  logic             e_wb_sel,
  input  logic             e_jb_taken,
  input  logic             e_ecall,
  output logic             pc_stall,
  output logic             fd_stall,
  output logic             fd_flush,
  output logic             de_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, LU_STALL, DRAIN, HALT} state_t;

  // Reload values are only used when the matching parameter makes them non-negative.
  localparam logic [2:0]       DRAIN_INIT = 3'(DRAIN_CYCLES - 1);
  localparam logic [2:0]       LU_INIT    = 3'(LOAD_LAT - 2);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu;
  logic             stall_inc;
  logic             flush_inc;

  assign lu = e_wb_en & e_wb_sel & (e_rd_index != 5'd0) &
              ((d_rs1_used & (d_rs1_index == e_rd_index)) |
               (d_rs2_used & (d_rs2_index == e_rd_index)));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_stall  = 1'b0;
    fd_stall  = 1'b0;
    fd_flush  = 1'b0;
    de_flush  = 1'b0;
    halt      = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;

    case (state_q)
      RUN: begin
        if (e_ecall) begin
          pc_stall = 1'b1;
          fd_flush = 1'b1;
          de_flush = 1'b1;
          if (DRAIN_CYCLES == 0) begin
            state_d = HALT;
          end else begin
            cnt_d   = DRAIN_INIT;
            state_d = DRAIN;
          end
        end else if (e_jb_taken) begin
          fd_flush  = 1'b1;
          de_flush  = 1'b1;
          flush_inc = 1'b1;
        end else if (lu) begin
          pc_stall  = 1'b1;
          fd_stall  = 1'b1;
          de_flush  = 1'b1;
          stall_inc = 1'b1;
          if (LOAD_LAT > 1) begin
            cnt_d   = LU_INIT;
            state_d = LU_STALL;
          end
        end
      end
      // Execute holds a bubble here, so its redirect/ecall/hazard inputs are stale.
      LU_STALL: begin
        pc_stall  = 1'b1;
        fd_stall  = 1'b1;
        de_flush  = 1'b1;
        stall_inc = 1'b1;
        if (cnt_q == 3'd0) state_d = RUN;
        else               cnt_d   = cnt_q - 3'd1;
      end
      DRAIN: begin
        pc_stall = 1'b1;
        fd_flush = 1'b1;
        de_flush = 1'b1;
        if (cnt_q == 3'd0) state_d = HALT;
        else               cnt_d   = cnt_q - 3'd1;
      end
      HALT: begin
        pc_stall = 1'b1;
        fd_flush = 1'b1;
        de_flush = 1'b1;
        halt     = 1'b1;
      end
      default: state_d = RUN;
    endcase

    if (rst) begin
      pc_stall  = 1'b0;
      fd_stall  = 1'b0;
      fd_flush  = 1'b0;
      de_flush  = 1'b0;
      halt      = 1'b0;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
    end

    stall_cnt_d = (stall_inc && stall_cnt_q != CNT_MAX) ? stall_cnt_q + CNT_ONE : stall_cnt_q;
    flush_cnt_d = (flush_inc && flush_cnt_q != CNT_MAX) ? flush_cnt_q + CNT_ONE : flush_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= 3'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed bench for hazard_ctrl
// u_a: LOAD_LAT=1, CNT_W=4; u_b: LOAD_LAT=3, CNT_W=32; both DRAIN_CYCLES=2, shared inputs.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  d_rs1_index, d_rs2_index, e_rd_index;
  logic        d_rs1_used, d_rs2_used, e_wb_en, e_wb_sel, e_jb_taken, e_ecall;

  logic        a_pc, a_fs, a_ff, a_df, a_h;
  logic        b_pc, b_fs, b_ff, b_df, b_h;
  logic [3:0]  a_stall, a_flush;
  logic [31:0] b_stall, b_flush;
  logic [4:0]  ctl_a, ctl_b;

  int checks = 0;
  int errors = 0;

  // {pc_stall, fd_stall, fd_flush, de_flush, halt}
  localparam logic [4:0] C_IDLE  = 5'b00000;
  localparam logic [4:0] C_LU    = 5'b11010;
  localparam logic [4:0] C_JB    = 5'b00110;
  localparam logic [4:0] C_DRAIN = 5'b10110;
  localparam logic [4:0] C_HALT  = 5'b10111;

  assign ctl_a = {a_pc, a_fs, a_ff, a_df, a_h};
  assign ctl_b = {b_pc, b_fs, b_ff, b_df, b_h};

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_LAT(1), .DRAIN_CYCLES(2), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst),
    .d_rs1_index(d_rs1_index), .d_rs2_index(d_rs2_index),
    .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used),
    .e_rd_index(e_rd_index), .e_wb_en(e_wb_en), .e_wb_sel(e_wb_sel),
    .e_jb_taken(e_jb_taken), .e_ecall(e_ecall),
    .pc_stall(a_pc), .fd_stall(a_fs), .fd_flush(a_ff), .de_flush(a_df), .halt(a_h),
    .stall_cnt(a_stall), .flush_cnt(a_flush)
  );

  hazard_ctrl #(.LOAD_LAT(3), .DRAIN_CYCLES(2), .CNT_W(32)) u_b (
    .clk(clk), .rst(rst),
    .d_rs1_index(d_rs1_index), .d_rs2_index(d_rs2_index),
    .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used),
    .e_rd_index(e_rd_index), .e_wb_en(e_wb_en), .e_wb_sel(e_wb_sel),
    .e_jb_taken(e_jb_taken), .e_ecall(e_ecall),
    .pc_stall(b_pc), .fd_stall(b_fs), .fd_flush(b_ff), .de_flush(b_df), .halt(b_h),
    .stall_cnt(b_stall), .flush_cnt(b_flush)
  );

  task automatic clr_inputs();
    d_rs1_index = 5'd0; d_rs2_index = 5'd0; e_rd_index = 5'd0;
    d_rs1_used = 1'b0; d_rs2_used = 1'b0; e_wb_en = 1'b0; e_wb_sel = 1'b0;
    e_jb_taken = 1'b0; e_ecall = 1'b0;
  endtask

  // lw x5 followed by add x6,x5,x1
  task automatic set_lu();
    clr_inputs();
    e_rd_index = 5'd5; e_wb_en = 1'b1; e_wb_sel = 1'b1;
    d_rs1_index = 5'd5; d_rs1_used = 1'b1; d_rs2_index = 5'd1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_lu();
    e_jb_taken = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ctl_a !== C_IDLE) begin errors++; $display("FAIL reset_ctl_a got %b exp %b", ctl_a, C_IDLE); end
    checks++; if (ctl_b !== C_IDLE) begin errors++; $display("FAIL reset_ctl_b got %b exp %b", ctl_b, C_IDLE); end
    step();
    rst = 1'b0;
    clr_inputs();
    checks++; if (a_stall !== 4'd0) begin errors++; $display("FAIL reset_stall_a got %0d exp 0", a_stall); end
    checks++; if (a_flush !== 4'd0) begin errors++; $display("FAIL reset_flush_a got %0d exp 0", a_flush); end
    checks++; if (b_stall !== 32'd0) begin errors++; $display("FAIL reset_stall_b got %0d exp 0", b_stall); end
    @(negedge clk);
    checks++; if (ctl_a !== C_IDLE) begin errors++; $display("FAIL idle_ctl_a got %b exp %b", ctl_a, C_IDLE); end
    step();
  endtask

  task automatic test_load_use();
    set_lu();
    @(negedge clk);
    checks++; if (ctl_a !== C_LU) begin errors++; $display("FAIL lu1_ctl_a got %b exp %b", ctl_a, C_LU); end
    checks++; if (ctl_b !== C_LU) begin errors++; $display("FAIL lu1_ctl_b got %b exp %b", ctl_b, C_LU); end
    step();
    clr_inputs();
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      checks++; if (ctl_a !== C_IDLE) begin errors++; $display("FAIL lu_ctl_a cyc%0d got %b exp %b", c, ctl_a, C_IDLE); end
      checks++;
      if (ctl_b !== ((c <= 3) ? C_LU : C_IDLE)) begin
        errors++; $display("FAIL lu_ctl_b cyc%0d got %b exp %b", c, ctl_b, (c <= 3) ? C_LU : C_IDLE);
      end
      if (c < 4) step();
    end
    checks++; if (a_stall !== 4'd1) begin errors++; $display("FAIL lu_stall_a got %0d exp 1", a_stall); end
    checks++; if (b_stall !== 32'd3) begin errors++; $display("FAIL lu_stall_b got %0d exp 3", b_stall); end
    step();
  endtask

  task automatic test_no_hazard();
    for (int p = 0; p < 3; p++) begin
      set_lu();
      case (p)
        0: begin e_rd_index = 5'd0; d_rs1_index = 5'd0; end
        1: d_rs1_used = 1'b0;
        default: e_wb_sel = 1'b0;
      endcase
      @(negedge clk);
      checks++; if (ctl_a !== C_IDLE) begin errors++; $display("FAIL nohaz%0d_ctl_a got %b exp %b", p, ctl_a, C_IDLE); end
      checks++; if (ctl_b !== C_IDLE) begin errors++; $display("FAIL nohaz%0d_ctl_b got %b exp %b", p, ctl_b, C_IDLE); end
      step();
    end
    clr_inputs();
    checks++; if (a_stall !== 4'd1) begin errors++; $display("FAIL nohaz_stall_a got %0d exp 1", a_stall); end
    checks++; if (b_stall !== 32'd3) begin errors++; $display("FAIL nohaz_stall_b got %0d exp 3", b_stall); end
  endtask

  task automatic test_dual_source();
    set_lu();
    d_rs2_index = 5'd5; d_rs2_used = 1'b1;
    @(negedge clk);
    checks++; if (ctl_a !== C_LU) begin errors++; $display("FAIL dual_ctl_a got %b exp %b", ctl_a, C_LU); end
    step();
    clr_inputs();
    step();
    step();
    checks++; if (a_stall !== 4'd2) begin errors++; $display("FAIL dual_stall_a got %0d exp 2", a_stall); end
    checks++; if (b_stall !== 32'd6) begin errors++; $display("FAIL dual_stall_b got %0d exp 6", b_stall); end
  endtask

  task automatic test_jb_priority();
    set_lu();
    e_jb_taken = 1'b1;
    @(negedge clk);
    checks++; if (ctl_a !== C_JB) begin errors++; $display("FAIL jb_ctl_a got %b exp %b", ctl_a, C_JB); end
    checks++; if (ctl_b !== C_JB) begin errors++; $display("FAIL jb_ctl_b got %b exp %b", ctl_b, C_JB); end
    step();
    clr_inputs();
    checks++; if (a_flush !== 4'd1) begin errors++; $display("FAIL jb_flush_a got %0d exp 1", a_flush); end
    checks++; if (b_flush !== 32'd1) begin errors++; $display("FAIL jb_flush_b got %0d exp 1", b_flush); end
    checks++; if (a_stall !== 4'd2) begin errors++; $display("FAIL jb_stall_a got %0d exp 2", a_stall); end
    checks++; if (b_stall !== 32'd6) begin errors++; $display("FAIL jb_stall_b got %0d exp 6", b_stall); end
  endtask

  task automatic test_saturation();
    set_lu();
    for (int i = 0; i < 16; i++) step();
    clr_inputs();
    checks++; if (a_stall !== 4'd15) begin errors++; $display("FAIL sat_stall_a got %0d exp 15", a_stall); end
    step();
    step();
    checks++; if (a_stall !== 4'd15) begin errors++; $display("FAIL sat_hold_a got %0d exp 15", a_stall); end
    checks++; if (b_stall !== 32'd24) begin errors++; $display("FAIL sat_stall_b got %0d exp 24", b_stall); end
  endtask

  task automatic test_ecall();
    clr_inputs();
    e_ecall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (ctl_a !== C_DRAIN) begin errors++; $display("FAIL drain_ctl_a cyc%0d got %b exp %b", c, ctl_a, C_DRAIN); end
      checks++; if (ctl_b !== C_DRAIN) begin errors++; $display("FAIL drain_ctl_b cyc%0d got %b exp %b", c, ctl_b, C_DRAIN); end
      step();
      clr_inputs();
    end
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 1) begin set_lu(); e_jb_taken = 1'b1; end
      else begin clr_inputs(); e_ecall = 1'b1; end
      @(negedge clk);
      checks++; if (ctl_a !== C_HALT) begin errors++; $display("FAIL halt_ctl_a cyc%0d got %b exp %b", i, ctl_a, C_HALT); end
      checks++; if (ctl_b !== C_HALT) begin errors++; $display("FAIL halt_ctl_b cyc%0d got %b exp %b", i, ctl_b, C_HALT); end
      step();
    end
    clr_inputs();
    checks++; if (a_flush !== 4'd1) begin errors++; $display("FAIL halt_flush_a got %0d exp 1", a_flush); end
    checks++; if (a_stall !== 4'd15) begin errors++; $display("FAIL halt_stall_a got %0d exp 15", a_stall); end
  endtask

  task automatic test_reset_from_halt();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (ctl_a !== C_IDLE) begin errors++; $display("FAIL rsthalt_ctl_a got %b exp %b", ctl_a, C_IDLE); end
    checks++; if (ctl_b !== C_IDLE) begin errors++; $display("FAIL rsthalt_ctl_b got %b exp %b", ctl_b, C_IDLE); end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (ctl_a !== C_IDLE) begin errors++; $display("FAIL post_rst_ctl_a got %b exp %b", ctl_a, C_IDLE); end
    checks++; if (a_stall !== 4'd0) begin errors++; $display("FAIL post_rst_stall_a got %0d exp 0", a_stall); end
    checks++; if (a_flush !== 4'd0) begin errors++; $display("FAIL post_rst_flush_a got %0d exp 0", a_flush); end
    checks++; if (b_stall !== 32'd0) begin errors++; $display("FAIL post_rst_stall_b got %0d exp 0", b_stall); end
    step();
    set_lu();
    @(negedge clk);
    checks++; if (ctl_a !== C_LU) begin errors++; $display("FAIL post_rst_lu_a got %b exp %b", ctl_a, C_LU); end
    checks++; if (ctl_b !== C_LU) begin errors++; $display("FAIL post_rst_lu_b got %b exp %b", ctl_b, C_LU); end
    step();
    clr_inputs();
    checks++; if (a_stall !== 4'd1) begin errors++; $display("FAIL post_rst_cnt_a got %0d exp 1", a_stall); end
  endtask

  initial begin
    rst = 1'b1;
    clr_inputs();
    step();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_dual_source();
    test_jb_priority();
    test_saturation();
    test_ecall();
    test_reset_from_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
